if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage of the RISC-V pipeline. Owns the program counter, issues instruction-memory requests over a req/gnt/rvalid handshake, and presents fetched instructions with their PC to the IF/ID pipeline register. Honours back-pressure from the stall signal that freezes IF/ID, and discards or kills instructions on a redirect from branch/jump resolution. Allows one outstanding memory request, and has a one-entry skid buffer so a response arriving during a stall is never lost.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- clk  in  1: clock; all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- stall  in  1: IF/ID is not accepting this cycle. Same signal as the IF/ID enable, inverted.
- redirect  in  1: single-cycle pulse; kill fetched/in-flight instructions and restart at redirect_pc.
- redirect_pc  in  32: new fetch PC; bits [1:0] forced to 0 internally.
- imem_req  out  1: request valid; combinational, equal to (state==REQ).
- imem_addr  out  32: word-aligned fetch address; equals pc_q.
- imem_gnt  in  1: request accepted this cycle (may equal imem_req same cycle).
- imem_rvalid  in  1: response data valid; arrives at least 1 cycle after gnt.
- imem_rdata  in  32: instruction word.
- if_pc  out  32: PC of presented instruction (registered).
- if_instr  out  32: presented instruction (registered); 32'h00000013 when if_valid=0.
- if_valid  out  1: if_pc/if_instr hold a live instruction (registered).

## Operation
- States: REQ, WAIT, BUF, DROP.
- Registers: pc_q, output slot (if_pc, if_instr, if_valid), skid slot (skid_pc, skid_instr, skid_valid).
- consume = if_valid && !stall && !redirect. When consume is true, the output slot empties at the end of the cycle.
- REQ: imem_req=1 and imem_addr=pc_q. On gnt, go to WAIT. Without gnt, stay in REQ with imem_addr held stable.
- WAIT: imem_req=0.
  - On rvalid, if the output slot is free or being consumed: load rdata and pc_q into the output slot, set if_valid=1, set pc_q+=4, go to REQ.
  - On rvalid, if the output slot is full and stalled: load the skid slot, set pc_q+=4, go to BUF.
- BUF: no request. On consume, move the skid slot into the output slot, clear skid_valid, go to REQ.
- DROP: no request. Waits for the rvalid that belongs to a killed request, discards it, then goes to REQ.
- When the output slot is consumed with no new load, clear if_valid and set if_instr to NOP. if_pc holds its last value.
- Redirect has the highest priority and overrides stall, gnt, and rvalid:
  - Set pc_q to {redirect_pc[31:2],2'b00}.
  - Clear if_valid and set if_instr to NOP. Clear skid_valid.
  - From REQ without gnt: stay in REQ. The address changes to the new PC next cycle.
  - From REQ with gnt in the same cycle: go to DROP, because the old request is now in flight.
  - From WAIT without rvalid: go to DROP.
  - From WAIT with rvalid in the same cycle: discard the data and go to REQ.
  - From BUF: go to REQ.
  - From DROP: stay in DROP with the PC updated. On rvalid in the same cycle, go to REQ.
- rvalid received in REQ or BUF is a protocol error: ignore it, with no state change.
- PC arithmetic is 32-bit modulo. 0xFFFF_FFFC+4 wraps to 0x0000_0000.

## Timing
- Reset (rst high at an edge) gives: state=REQ, pc_q=RESET_PC, if_pc=0, if_instr=32'h00000013, if_valid=0, skid_valid=0.
  - imem_req is 1 from the first cycle after reset release, with imem_addr=RESET_PC.
- Reset mid-transaction abandons any outstanding response. A late rvalid seen in REQ is ignored per the rule above.
- Zero-wait memory (gnt with req, rvalid next cycle):
  - req/gnt in cycle n, rvalid in n+1, if_valid=1 from n+2.
  - Next req is in n+2, so steady-state throughput is 1 instruction per 2 cycles.
- Redirect in cycle n: if_valid=0 from n+1. With zero-wait memory, imem_addr=redirect_pc with req=1 no later than n+2.
- While stall is held, if_pc, if_instr and if_valid are stable. At most two instructions (output slot plus skid slot) are held, and they are released in program order.

## Test plan
- Reset, then zero-wait memory returning 0xA0+addr: imem_addr runs 0x0, 0x4, 0x8. if_pc runs 0x0, 0x4, 0x8, each valid for one cycle every 2 cycles, and if_instr matches.
- Stall asserted for 6 cycles while if_pc=0x4 is valid:
  - Outputs stay frozen.
  - The instruction at 0x8 goes to the skid slot and no request is made to 0xC during the stall.
  - After stall drops, 0x8 is presented next, then fetching resumes at 0xC.
- redirect_pc=0x103 pulsed while in WAIT for 0x10: the late rvalid is discarded, the next request address is 0x100, if_valid=0 until instruction 0x100 appears, and 0x10 is never presented.
- imem_gnt delayed 3 cycles: imem_req stays high and imem_addr stays constant; no PC advance until gnt.
- redirect, stall and rvalid in the same cycle (output full): the rvalid data is dropped, if_valid=0 next cycle, and the next request is at redirect_pc.
- rst pulsed while in WAIT, with a stale rvalid one cycle after reset: outputs take their reset values, the stale data is ignored, and the first request is to RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid fetch and
// feeds the IF/ID register through an output slot backed by a one-entry skid buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StBuf, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic        consume;

  assign consume   = out_valid_q && !stall && !redirect;
  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;
  assign if_pc     = out_pc_q;
  assign if_instr  = out_instr_q;
  assign if_valid  = out_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_valid_d  = out_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_valid_d = skid_valid_q;

    // A consumed slot empties unless a load below refills it in the same cycle.
    if (consume) begin
      out_valid_d = 1'b0;
      out_instr_d = Nop;
    end

    if (redirect) begin
      pc_d         = redirect_pc & ~32'd3;
      out_valid_d  = 1'b0;
      out_instr_d  = Nop;
      skid_valid_d = 1'b0;
      unique case (state_q)
        StReq:   state_d = imem_gnt ? StDrop : StReq;
        StWait:  state_d = imem_rvalid ? StReq : StDrop;
        StBuf:   state_d = StReq;
        StDrop:  state_d = imem_rvalid ? StReq : StDrop;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_gnt) state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            pc_d = pc_q + 32'd4;
            if (!out_valid_q || consume) begin
              out_pc_d    = pc_q;
              out_instr_d = imem_rdata;
              out_valid_d = 1'b1;
              state_d     = StReq;
            end else begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata;
              skid_valid_d = 1'b1;
              state_d      = StBuf;
            end
          end
        end
        StBuf: begin
          if (consume) begin
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
            state_d      = StReq;
          end
        end
        StDrop: begin
          if (imem_rvalid) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      out_pc_q     <= 32'h0;
      out_instr_q  <= Nop;
      out_valid_q  <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= Nop;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_valid_q  <= out_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with tunable grant/response delays, a per-cycle
// stream model (program order, NOP on empty, hold on stall, kill on redirect) and directed pins.
module tb_if_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk, rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_instr;
  logic        if_valid;

  if_fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int gnt_delay = 0;
  int resp_delay = 1;
  int req_age = 0;
  int n_pres = 0;

  typedef struct {int due; logic [31:0] addr;} pend_t;
  pend_t pend[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h0000_00A0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, exp, cyc - c0);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: grants after gnt_delay cycles of pending request, answers resp_delay cycles later.
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend[0].addr);
        void'(pend.pop_front());
      end
      imem_gnt = imem_req && (req_age >= gnt_delay);
    end
  end

  initial forever begin
    @(negedge clk);
    if (imem_req && imem_gnt && !rst) pend.push_back('{due: cyc + resp_delay, addr: imem_addr});
    if (imem_req && !imem_gnt) req_age++;
    else req_age = 0;
  end

  // Stream model: every cycle the outputs must be consistent with program order from the
  // last reset/redirect target, frozen while stalled, and empty right after a kill.
  initial begin
    logic        armed, p_rst, p_redir, p_valid, p_stall;
    logic [31:0] p_pc, p_instr, exp_pc, exp_fetch;
    armed = 0; p_rst = 0; p_redir = 0; p_valid = 0; p_stall = 0;
    p_pc = '0; p_instr = '0; exp_pc = ResetPc; exp_fetch = ResetPc;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("instr_matches_pc", if_instr, if_valid ? mem(if_pc) : Nop);
        if (p_rst || p_redir) begin
          chk("empty_after_kill", {31'b0, if_valid}, 32'd0);
        end else if (p_valid && p_stall) begin
          chk("hold_valid", {31'b0, if_valid}, 32'd1);
          chk("hold_pc", if_pc, p_pc);
          chk("hold_instr", if_instr, p_instr);
        end else if (if_valid) begin
          chk("program_order", if_pc, exp_pc);
          exp_pc = exp_pc + 32'd4;
          n_pres++;
        end
        if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
      end
      if (rst) begin
        armed = 1;
        exp_pc = ResetPc;
        exp_fetch = ResetPc;
      end else if (redirect) begin
        exp_pc = redirect_pc & ~32'd3;
        exp_fetch = redirect_pc & ~32'd3;
      end else if (imem_req && imem_gnt) begin
        exp_fetch = exp_fetch + 32'd4;
      end
      p_rst = rst; p_redir = redirect; p_valid = if_valid; p_stall = stall;
      p_pc = if_pc; p_instr = if_instr;
    end
  end

  task automatic go(input int k);
    while (cyc - c0 < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic pin_out(input string n, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({n, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    chk({n, "_pc"}, if_pc, pc);
    chk({n, "_instr"}, if_instr, ins);
  endtask

  task automatic pin_req(input string n, input logic r, input logic [31:0] a);
    chk({n, "_req"}, {31'b0, imem_req}, {31'b0, r});
    if (r) chk({n, "_addr"}, imem_addr, a);
  endtask

  initial begin
    int n0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    c0 = cyc;
    look(); pin_out("rst", 1'b0, 32'h0, Nop); pin_req("rst", 1'b1, 32'h0);
    go(2); look(); pin_out("f0", 1'b1, 32'h0, 32'hA0); pin_req("f0", 1'b1, 32'h4);
    go(3); look(); pin_out("gap", 1'b0, 32'h0, Nop);
    // Stall six cycles while 0x4 is presented; 0x8 must land in the skid slot.
    go(4); stall = 1'b1;
    look(); pin_out("f4", 1'b1, 32'h4, 32'hA4); pin_req("f4", 1'b1, 32'h8);
    for (int k = 5; k <= 9; k++) begin
      go(k); look(); pin_req("stall_noreq", 1'b0, 32'h0); chk("stall_pc", if_pc, 32'h4);
    end
    go(10); stall = 1'b0;
    look(); pin_out("stall_last", 1'b1, 32'h4, 32'hA4); pin_req("stall_last", 1'b0, 32'h0);
    go(11); look(); pin_out("skid", 1'b1, 32'h8, 32'hA8); pin_req("skid", 1'b1, 32'hC);
    // Redirect while waiting on a slow response for 0x10.
    go(13); resp_delay = 3;
    look(); pin_out("fc", 1'b1, 32'hC, 32'hAC);
    go(14); redirect = 1'b1; redirect_pc = 32'h103;
    look(); chk("redir_w_valid", {31'b0, if_valid}, 32'd0);
    go(15); redirect = 1'b0; resp_delay = 1;
    look(); pin_req("drop", 1'b0, 32'h0);
    go(16); look(); chk("late_rvalid_valid", {31'b0, if_valid}, 32'd0); pin_req("drop2", 1'b0, 32'h0);
    go(17); look(); pin_req("redir_tgt", 1'b1, 32'h100); chk("redir_tgt_valid", {31'b0, if_valid}, 32'd0);
    // Grant held back three cycles.
    go(18); gnt_delay = 3;
    go(19); look(); pin_out("f100", 1'b1, 32'h100, 32'h1A0); pin_req("gdly0", 1'b1, 32'h104);
    for (int k = 20; k <= 22; k++) begin
      go(k); look(); pin_req("gdly", 1'b1, 32'h104);
    end
    go(23); gnt_delay = 0;
    look(); pin_req("gdly_done", 1'b0, 32'h0);
    // Redirect, stall and rvalid together with the output slot full.
    go(24); stall = 1'b1;
    look(); pin_out("f104", 1'b1, 32'h104, 32'h1A4);
    go(25); redirect = 1'b1; redirect_pc = 32'h200;
    look(); pin_out("triple", 1'b1, 32'h104, 32'h1A4);
    go(26); redirect = 1'b0; stall = 1'b0;
    look(); chk("triple_kill", {31'b0, if_valid}, 32'd0); pin_req("triple", 1'b1, 32'h200);
    // Reset while waiting; the stale response arrives in the first cycle after reset.
    go(28); resp_delay = 2;
    look(); pin_out("f200", 1'b1, 32'h200, 32'h2A0);
    go(29); rst = 1'b1; resp_delay = 1;
    go(30); rst = 1'b0;
    look(); pin_out("rst2", 1'b0, 32'h0, Nop); pin_req("rst2", 1'b1, ResetPc);
    go(31); look(); chk("stale_ignored", {31'b0, if_valid}, 32'd0);
    // Redirect with a same-cycle grant, to the top word so the PC wraps.
    go(32); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    look(); pin_out("rst2_f0", 1'b1, 32'h0, 32'hA0); pin_req("rst2_f0", 1'b1, 32'h4);
    go(33); redirect = 1'b0;
    look(); chk("wrap_kill", {31'b0, if_valid}, 32'd0); pin_req("wrap_drop", 1'b0, 32'h0);
    go(34); look(); pin_req("wrap_tgt", 1'b1, 32'hFFFF_FFFC);
    go(36); look(); pin_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_009C);
    pin_req("wrap", 1'b1, 32'h0);
    // Mixed traffic judged by the stream model alone.
    n0 = n_pres;
    for (int k = 37; k < 117; k++) begin
      go(k);
      stall = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom_range(0, 255);
      gnt_delay = $urandom_range(0, 2);
      resp_delay = $urandom_range(1, 3);
    end
    go(117); stall = 1'b0; redirect = 1'b0;
    go(130); look();
    chk("progress", {31'b0, (n_pres - n0) >= 5}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
